wts_timer_scheduler: RTL and testbench
======================================

# wts_timer_scheduler

Generates the periodic trigger pulses that drive the two interrupt timers of the Wave Table Sound core. A shared free-running prescaler produces a base tick, and two independent programmable down-counters consume it. Each counter emits a one-clock `timerN_trigger` pulse when it expires. The outputs connect directly to `timer1_trigger`/`timer2_trigger` of the timer interrupt block; enable, clear and interrupt handling stay there.

## Interface
- `PRE_DIV`, default 256: prescaler division ratio, clk cycles per tick, ≥2.
- `CNT_W`, default 12: period counter width.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `reg_timer1_period` in CNT_W: timer1 period in ticks. Sampled at load and at each auto-reload.
- `reg_timer1_load` in 1: one-cycle strobe that loads the period and starts timer1.
- `reg_timer1_stop` in 1: one-cycle strobe that stops timer1.
- `reg_timer1_repeat` in 1: 1 = auto-reload, 0 = one-shot. Sampled at expiry.
- `reg_timer2_period`, `reg_timer2_load`, `reg_timer2_stop`, `reg_timer2_repeat`: same as timer1, for timer2.
- `timer1_trigger` out 1: one-clk expiry pulse.
- `timer2_trigger` out 1: one-clk expiry pulse.
- `timer1_running` out 1: timer1 FSM is in RUN.
- `timer2_running` out 1: timer2 FSM is in RUN.
- `timer1_count` out CNT_W: current timer1 count, for readback.
- `timer2_count` out CNT_W: current timer2 count, for readback.

## Operation
- Prescaler: counts 0..PRE_DIV-1 and wraps to 0.
  - `tick` is high in the cycle where the prescaler equals PRE_DIV-1.
  - Free-running; load and stop never touch it.
- Each channel is a two-state FSM: IDLE and RUN.
- IDLE:
  - count = 0.
  - On load with period ≠ 0: count ← period, go to RUN.
  - Load with period = 0 is ignored.
- RUN, on `tick`:
  - count > 1: count ← count-1.
  - count = 1: trigger. If repeat = 1 and period ≠ 0, count ← current period and stay in RUN. Otherwise count ← 0 and go to IDLE.
- Priority per channel, per cycle: stop > load > tick.
  - Stop: count ← 0, IDLE, no trigger, even if a tick hits the terminal count in the same cycle.
  - Load in RUN: restarts the count from the period. Any coincident tick/expiry is discarded with no trigger.
- Writing the period while in RUN does not change the current count; the new value takes effect at the next reload.
- Arithmetic is unsigned CNT_W. The count never wraps below 0; the max period is 2^CNT_W-1 ticks.
- The two channels are fully independent. Simultaneous expiry produces both triggers in the same cycle.

## Timing
- Reset values: prescaler 0, both FSMs IDLE, all counts 0, triggers 0, running 0.
- Reset asserted mid-run returns every register to its reset value on the next edge. No trigger is issued in the cycle after reset.
- Load strobe sampled at edge t: running = 1 and count = period are visible after edge t.
- Triggers are registered. Trigger is high for exactly the one cycle after the edge on which an expiring tick was sampled. In that same cycle, count shows the reloaded value (or 0 with running = 0).
- First trigger after load arrives (P-1)·PRE_DIV+1 to P·PRE_DIV clk cycles later, depending on prescaler phase. Following triggers in repeat mode are exactly P·PRE_DIV cycles apart.
- Running drops in the same cycle as the final one-shot trigger.

## Structure
- Shared package `wts_timer_pkg` holds:
  - state encodings ST_IDLE / ST_RUN;
  - the default CNT_W and PRE_DIV constants.
- Sub-module `wts_timer_channel`, parameterised by CNT_W:
  - contains the FSM, counter and trigger flop;
  - is instantiated twice.
- The top level holds only the prescaler and the two channel instances.

## Test plan
Simulation runs with PRE_DIV = 4 and CNT_W = 12.
- **Reset and one-shot:** reset, then load timer1 with period 3, repeat = 0. Expect one trigger 9–12 clks after load, then running = 0, count = 0, and no further triggers over 100 clks.
- **Repeat mode:** timer2 period 2, repeat = 1. Expect triggers exactly 8 clks apart. Change the period to 5 mid-run: the current interval stays 8, and every interval after the next reload is 20.
- **Stop and load priority:** stop on the same cycle as an expiring tick gives no trigger and IDLE. Load on an expiring tick gives no trigger, count = period, and the next trigger P ticks later.
- **Zero period and saturation:**
  - load with period 0: stays IDLE, no trigger;
  - period 4095 with repeat: interval is 16380 clks;
  - repeat with the period rewritten to 0 before expiry: goes IDLE after that trigger.
- **Simultaneous channels:** both channels loaded in the same cycle with period 3. Both triggers are high in the same single cycle.
- **Reset mid-run:** reset asserted while both channels run with count = 1. All outputs are 0 after the edge, and no trigger appears afterward.

Source files
------------

// File: rtl/wts_timer_pkg.sv
// wts_timer_pkg
// Shared definitions for the Wave Table Sound timer scheduler:
//   state_t      - per-channel FSM encoding (ST_IDLE / ST_RUN)
//   DEF_CNT_W    - default period counter width
//   DEF_PRE_DIV  - default prescaler division ratio (clk cycles per tick)
package wts_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_CNT_W   = 12;
  localparam int DEF_PRE_DIV = 256;

endpackage

// File: rtl/wts_timer_scheduler_if.sv
// wts_timer_scheduler_if
// Register-side bundle between the timer register block (master) and the
// timer scheduler (slave).
//   reg_timerN_period  - period in ticks, sampled at load and at auto-reload
//   reg_timerN_load    - one-cycle strobe: load period and start channel N
//   reg_timerN_stop    - one-cycle strobe: stop channel N
//   reg_timerN_repeat  - 1 = auto-reload, 0 = one-shot (sampled at expiry)
//   timerN_trigger     - one-clk expiry pulse to the timer interrupt block
//   timerN_running     - channel N FSM is in RUN
//   timerN_count       - current channel N count for readback
interface wts_timer_scheduler_if
  import wts_timer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic [CNT_W-1:0] reg_timer1_period;
  logic             reg_timer1_load;
  logic             reg_timer1_stop;
  logic             reg_timer1_repeat;
  logic [CNT_W-1:0] reg_timer2_period;
  logic             reg_timer2_load;
  logic             reg_timer2_stop;
  logic             reg_timer2_repeat;

  logic             timer1_trigger;
  logic             timer2_trigger;
  logic             timer1_running;
  logic             timer2_running;
  logic [CNT_W-1:0] timer1_count;
  logic [CNT_W-1:0] timer2_count;

  modport master (
    output reg_timer1_period, reg_timer1_load, reg_timer1_stop, reg_timer1_repeat,
    output reg_timer2_period, reg_timer2_load, reg_timer2_stop, reg_timer2_repeat,
    input  timer1_trigger, timer2_trigger, timer1_running, timer2_running,
    input  timer1_count, timer2_count
  );

  modport slave (
    input  reg_timer1_period, reg_timer1_load, reg_timer1_stop, reg_timer1_repeat,
    input  reg_timer2_period, reg_timer2_load, reg_timer2_stop, reg_timer2_repeat,
    output timer1_trigger, timer2_trigger, timer1_running, timer2_running,
    output timer1_count, timer2_count
  );

endinterface

// File: rtl/wts_timer_channel.sv
// wts_timer_channel
// One programmable down-counter consuming the shared prescaler tick.
//   clk, reset   - system clock, synchronous active-high reset
//   tick         - base tick from the shared prescaler
//   period       - period in ticks
//   load, stop   - one-cycle control strobes (stop > load > tick)
//   auto_reload  - 1 = reload on expiry, 0 = one-shot
//   trigger      - registered one-clk expiry pulse
//   running      - FSM is in RUN
//   count        - current count (0 whenever IDLE)
module wts_timer_channel
  import wts_timer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [CNT_W-1:0] period,
  input  logic             load,
  input  logic             stop,
  input  logic             auto_reload,
  output logic             trigger,
  output logic             running,
  output logic [CNT_W-1:0] count
);

  state_t state;

  // NOTE: reset is synchronous, so it is a branch inside the clocked block,
  // not an entry in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: non-blocking assignments throughout, so every decision below
      // sees the pre-edge values of state and count.
      state   <= ST_IDLE;
      count   <= '0;
      trigger <= 1'b0;
    end else begin
      trigger <= 1'b0;
      if (stop) begin
        // Stop wins even over a tick reaching the terminal count.
        state <= ST_IDLE;
        count <= '0;
      end else if (load && (period != '0)) begin
        // Restart from the period; a coincident tick is discarded.
        // A load with period 0 is ignored outright, so the tick still counts.
        state <= ST_RUN;
        count <= period;
      end else if (tick && (state == ST_RUN)) begin
        if (count > CNT_W'(1)) begin
          count <= count - CNT_W'(1);
        end else begin
          trigger <= 1'b1;
          if (auto_reload && (period != '0)) begin
            count <= period;
          end else begin
            state <= ST_IDLE;
            count <= '0;
          end
        end
      end
    end
  end

  // state is itself a flop, so running is a registered output.
  assign running = (state == ST_RUN);

endmodule

// File: rtl/wts_timer_scheduler.sv
// wts_timer_scheduler
// Periodic trigger generator for the two Wave Table Sound interrupt timers.
// A free-running prescaler produces one tick every PRE_DIV clocks; two
// independent wts_timer_channel instances count those ticks.
//   clk, reset - system clock, synchronous active-high reset
//   bus        - register-side bundle (slave modport): period/load/stop/
//                repeat per timer in, trigger/running/count per timer out
module wts_timer_scheduler
  import wts_timer_pkg::*;
#(
  parameter int PRE_DIV = DEF_PRE_DIV,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  wts_timer_scheduler_if.slave  bus
);

  localparam int            PW       = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE_DIV - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;

  // Free-running: load and stop never touch the prescaler, so the first
  // interval after a load depends on its phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  assign tick = (pre_cnt == PRE_LAST);

  wts_timer_channel #(.CNT_W(CNT_W)) u_timer1 (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .period      (bus.reg_timer1_period),
    .load        (bus.reg_timer1_load),
    .stop        (bus.reg_timer1_stop),
    .auto_reload (bus.reg_timer1_repeat),
    .trigger     (bus.timer1_trigger),
    .running     (bus.timer1_running),
    .count       (bus.timer1_count)
  );

  wts_timer_channel #(.CNT_W(CNT_W)) u_timer2 (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .period      (bus.reg_timer2_period),
    .load        (bus.reg_timer2_load),
    .stop        (bus.reg_timer2_stop),
    .auto_reload (bus.reg_timer2_repeat),
    .trigger     (bus.timer2_trigger),
    .running     (bus.timer2_running),
    .count       (bus.timer2_count)
  );

endmodule

// File: tb/tb_wts_timer_scheduler.sv
// tb_wts_timer_scheduler
// Directed bench for wts_timer_scheduler with PRE_DIV = 4, CNT_W = 12.
// Inputs are driven and outputs sampled on the falling edge. cyc counts
// rising edges since reset release, so cyc % PRE_DIV at a falling edge is
// the prescaler value the next rising edge will see.
module tb_wts_timer_scheduler;
  import wts_timer_pkg::*;

  localparam int PRE_DIV = 4;
  localparam int CNT_W   = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wts_timer_scheduler_if #(.CNT_W(CNT_W)) bus ();

  wts_timer_scheduler #(.PRE_DIV(PRE_DIV), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Clocks from the load edge to the expiry edge, given prescaler phase p
  // seen by the load edge (a tick on the load edge itself is discarded).
  function automatic int first_trig(input int p, input int per);
    int k;
    k = (PRE_DIV - 1 - p) % PRE_DIV;
    if (k == 0) k = PRE_DIV;
    return k + (per - 1) * PRE_DIV;
  endfunction

  task automatic idle_inputs();
    bus.reg_timer1_period = '0; bus.reg_timer1_load = 1'b0;
    bus.reg_timer1_stop   = 1'b0; bus.reg_timer1_repeat = 1'b0;
    bus.reg_timer2_period = '0; bus.reg_timer2_load = 1'b0;
    bus.reg_timer2_stop   = 1'b0; bus.reg_timer2_repeat = 1'b0;
  endtask

  // Falling edges until channel ch triggers; n = -1 on timeout.
  task automatic wait_trig(input int ch, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if ((ch == 1 ? bus.timer1_trigger : bus.timer2_trigger) === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  // Waits until timer1 count is 1 and the next rising edge carries a tick.
  task automatic wait_expiring(input int max, output int ok);
    ok = 0;
    for (int i = 0; i <= max; i++) begin
      if (bus.timer1_count === 12'd1 && (cyc % PRE_DIV) == PRE_DIV - 1) begin
        ok = 1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic count_trigs(input int cycles, output int t1, output int t2);
    t1 = 0; t2 = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.timer1_trigger === 1'b1) t1++;
      if (bus.timer2_trigger === 1'b1) t2++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    checks++; if (bus.timer1_trigger !== 1'b0) begin errors++; $display("FAIL rst_trig1: got %b want 0", bus.timer1_trigger); end
    checks++; if (bus.timer2_trigger !== 1'b0) begin errors++; $display("FAIL rst_trig2: got %b want 0", bus.timer2_trigger); end
    checks++; if (bus.timer1_running !== 1'b0) begin errors++; $display("FAIL rst_run1: got %b want 0", bus.timer1_running); end
    checks++; if (bus.timer2_running !== 1'b0) begin errors++; $display("FAIL rst_run2: got %b want 0", bus.timer2_running); end
    checks++; if (bus.timer1_count !== 12'd0) begin errors++; $display("FAIL rst_cnt1: got %0d want 0", bus.timer1_count); end
    checks++; if (bus.timer2_count !== 12'd0) begin errors++; $display("FAIL rst_cnt2: got %0d want 0", bus.timer2_count); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_one_shot();
    int exp, n, t1, t2;
    bus.reg_timer1_period = 12'd3; bus.reg_timer1_repeat = 1'b0; bus.reg_timer1_load = 1'b1;
    exp = first_trig(cyc % PRE_DIV, 3);
    @(negedge clk);
    bus.reg_timer1_load = 1'b0;
    checks++; if (bus.timer1_running !== 1'b1) begin errors++; $display("FAIL os_run_after_load: got %b want 1", bus.timer1_running); end
    checks++; if (bus.timer1_count !== 12'd3) begin errors++; $display("FAIL os_cnt_after_load: got %0d want 3", bus.timer1_count); end
    wait_trig(1, 20, n);
    checks++; if (n !== exp || n < 9 || n > 12) begin errors++; $display("FAIL os_latency: got %0d want %0d", n, exp); end
    checks++; if (bus.timer1_running !== 1'b0) begin errors++; $display("FAIL os_run_at_trig: got %b want 0", bus.timer1_running); end
    checks++; if (bus.timer1_count !== 12'd0) begin errors++; $display("FAIL os_cnt_at_trig: got %0d want 0", bus.timer1_count); end
    count_trigs(100, t1, t2);
    checks++; if (t1 !== 0) begin errors++; $display("FAIL os_extra_trigs: got %0d want 0", t1); end
  endtask

  task automatic test_repeat();
    int exp, n;
    bus.reg_timer2_period = 12'd2; bus.reg_timer2_repeat = 1'b1; bus.reg_timer2_load = 1'b1;
    exp = first_trig(cyc % PRE_DIV, 2);
    @(negedge clk);
    bus.reg_timer2_load = 1'b0;
    wait_trig(2, 20, n);
    checks++; if (n !== exp) begin errors++; $display("FAIL rep_first: got %0d want %0d", n, exp); end
    checks++; if (bus.timer2_count !== 12'd2) begin errors++; $display("FAIL rep_reload_cnt: got %0d want 2", bus.timer2_count); end
    wait_trig(2, 20, n);
    checks++; if (n !== 8) begin errors++; $display("FAIL rep_int1: got %0d want 8", n); end
    // Period rewritten right after a reload: current interval keeps the old period.
    bus.reg_timer2_period = 12'd5;
    wait_trig(2, 30, n);
    checks++; if (n !== 8) begin errors++; $display("FAIL rep_int_old_period: got %0d want 8", n); end
    checks++; if (bus.timer2_count !== 12'd5) begin errors++; $display("FAIL rep_new_reload_cnt: got %0d want 5", bus.timer2_count); end
    for (int k = 0; k < 2; k++) begin
      wait_trig(2, 30, n);
      checks++; if (n !== 20) begin errors++; $display("FAIL rep_int_new_period_%0d: got %0d want 20", k, n); end
    end
    bus.reg_timer2_stop = 1'b1;
    @(negedge clk);
    bus.reg_timer2_stop = 1'b0;
    checks++; if (bus.timer2_running !== 1'b0 || bus.timer2_count !== 12'd0) begin errors++; $display("FAIL rep_stop: got run=%b cnt=%0d want run=0 cnt=0", bus.timer2_running, bus.timer2_count); end
  endtask

  task automatic test_priority();
    int ok, n, t1, t2;
    // Stop coinciding with an expiring tick.
    bus.reg_timer1_period = 12'd2; bus.reg_timer1_repeat = 1'b1; bus.reg_timer1_load = 1'b1;
    @(negedge clk);
    bus.reg_timer1_load = 1'b0;
    wait_expiring(40, ok);
    checks++; if (ok !== 1) begin errors++; $display("FAIL stop_find_expiry: got %0d want 1", ok); end
    bus.reg_timer1_stop = 1'b1;
    @(negedge clk);
    bus.reg_timer1_stop = 1'b0;
    checks++; if (bus.timer1_trigger !== 1'b0) begin errors++; $display("FAIL stop_trig: got %b want 0", bus.timer1_trigger); end
    checks++; if (bus.timer1_running !== 1'b0 || bus.timer1_count !== 12'd0) begin errors++; $display("FAIL stop_idle: got run=%b cnt=%0d want run=0 cnt=0", bus.timer1_running, bus.timer1_count); end
    count_trigs(20, t1, t2);
    checks++; if (t1 !== 0) begin errors++; $display("FAIL stop_later_trigs: got %0d want 0", t1); end
    // Load coinciding with an expiring tick.
    bus.reg_timer1_period = 12'd2; bus.reg_timer1_repeat = 1'b0; bus.reg_timer1_load = 1'b1;
    @(negedge clk);
    bus.reg_timer1_load = 1'b0;
    wait_expiring(40, ok);
    checks++; if (ok !== 1) begin errors++; $display("FAIL load_find_expiry: got %0d want 1", ok); end
    bus.reg_timer1_period = 12'd3; bus.reg_timer1_load = 1'b1;
    @(negedge clk);
    bus.reg_timer1_load = 1'b0;
    checks++; if (bus.timer1_trigger !== 1'b0) begin errors++; $display("FAIL load_trig: got %b want 0", bus.timer1_trigger); end
    checks++; if (bus.timer1_count !== 12'd3 || bus.timer1_running !== 1'b1) begin errors++; $display("FAIL load_restart: got run=%b cnt=%0d want run=1 cnt=3", bus.timer1_running, bus.timer1_count); end
    // Load landed on a tick edge, so the next trigger is exactly 3 ticks away.
    wait_trig(1, 20, n);
    checks++; if (n !== 12) begin errors++; $display("FAIL load_next_trig: got %0d want 12", n); end
    checks++; if (bus.timer1_running !== 1'b0) begin errors++; $display("FAIL load_oneshot_end: got %b want 0", bus.timer1_running); end
  endtask

  task automatic test_zero_saturation();
    int exp, n, t1, t2;
    // Period 0 load is ignored.
    bus.reg_timer1_period = 12'd0; bus.reg_timer1_repeat = 1'b0; bus.reg_timer1_load = 1'b1;
    @(negedge clk);
    bus.reg_timer1_load = 1'b0;
    checks++; if (bus.timer1_running !== 1'b0 || bus.timer1_count !== 12'd0) begin errors++; $display("FAIL zero_load: got run=%b cnt=%0d want run=0 cnt=0", bus.timer1_running, bus.timer1_count); end
    count_trigs(20, t1, t2);
    checks++; if (t1 !== 0) begin errors++; $display("FAIL zero_trigs: got %0d want 0", t1); end
    // Maximum period with auto-reload.
    bus.reg_timer2_period = 12'd4095; bus.reg_timer2_repeat = 1'b1; bus.reg_timer2_load = 1'b1;
    exp = first_trig(cyc % PRE_DIV, 4095);
    @(negedge clk);
    bus.reg_timer2_load = 1'b0;
    checks++; if (bus.timer2_count !== 12'd4095) begin errors++; $display("FAIL sat_load_cnt: got %0d want 4095", bus.timer2_count); end
    wait_trig(2, 16400, n);
    checks++; if (n !== exp) begin errors++; $display("FAIL sat_first: got %0d want %0d", n, exp); end
    wait_trig(2, 16400, n);
    checks++; if (n !== 16380) begin errors++; $display("FAIL sat_interval: got %0d want 16380", n); end
    bus.reg_timer2_stop = 1'b1;
    @(negedge clk);
    bus.reg_timer2_stop = 1'b0;
    // Repeat mode with the period cleared before expiry ends after that trigger.
    bus.reg_timer1_period = 12'd2; bus.reg_timer1_repeat = 1'b1; bus.reg_timer1_load = 1'b1;
    exp = first_trig(cyc % PRE_DIV, 2);
    @(negedge clk);
    bus.reg_timer1_load = 1'b0;
    bus.reg_timer1_period = 12'd0;
    wait_trig(1, 20, n);
    checks++; if (n !== exp) begin errors++; $display("FAIL rep0_trig: got %0d want %0d", n, exp); end
    checks++; if (bus.timer1_running !== 1'b0 || bus.timer1_count !== 12'd0) begin errors++; $display("FAIL rep0_idle: got run=%b cnt=%0d want run=0 cnt=0", bus.timer1_running, bus.timer1_count); end
    count_trigs(20, t1, t2);
    checks++; if (t1 !== 0) begin errors++; $display("FAIL rep0_later_trigs: got %0d want 0", t1); end
  endtask

  task automatic test_simultaneous();
    int exp, n, t1, t2;
    bus.reg_timer1_period = 12'd3; bus.reg_timer1_repeat = 1'b0; bus.reg_timer1_load = 1'b1;
    bus.reg_timer2_period = 12'd3; bus.reg_timer2_repeat = 1'b0; bus.reg_timer2_load = 1'b1;
    exp = first_trig(cyc % PRE_DIV, 3);
    @(negedge clk);
    bus.reg_timer1_load = 1'b0; bus.reg_timer2_load = 1'b0;
    wait_trig(1, 20, n);
    checks++; if (n !== exp) begin errors++; $display("FAIL sim_trig1: got %0d want %0d", n, exp); end
    checks++; if (bus.timer2_trigger !== 1'b1) begin errors++; $display("FAIL sim_trig2_same_cycle: got %b want 1", bus.timer2_trigger); end
    count_trigs(10, t1, t2);
    checks++; if (t1 !== 0 || t2 !== 0) begin errors++; $display("FAIL sim_single_pulse: got t1=%0d t2=%0d want 0 0", t1, t2); end
  endtask

  task automatic test_reset_mid_run();
    int ok, t1, t2;
    bus.reg_timer1_period = 12'd2; bus.reg_timer1_repeat = 1'b1; bus.reg_timer1_load = 1'b1;
    bus.reg_timer2_period = 12'd2; bus.reg_timer2_repeat = 1'b1; bus.reg_timer2_load = 1'b1;
    @(negedge clk);
    bus.reg_timer1_load = 1'b0; bus.reg_timer2_load = 1'b0;
    wait_expiring(40, ok);
    checks++; if (ok !== 1 || bus.timer2_count !== 12'd1) begin errors++; $display("FAIL mid_find_expiry: got ok=%0d cnt2=%0d want 1 1", ok, bus.timer2_count); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({bus.timer1_trigger, bus.timer2_trigger, bus.timer1_running, bus.timer2_running} !== 4'b0000) begin errors++; $display("FAIL mid_rst_flags: got %b want 0000", {bus.timer1_trigger, bus.timer2_trigger, bus.timer1_running, bus.timer2_running}); end
    checks++; if (bus.timer1_count !== 12'd0 || bus.timer2_count !== 12'd0) begin errors++; $display("FAIL mid_rst_counts: got %0d %0d want 0 0", bus.timer1_count, bus.timer2_count); end
    count_trigs(30, t1, t2);
    checks++; if (t1 !== 0 || t2 !== 0) begin errors++; $display("FAIL mid_rst_later_trigs: got t1=%0d t2=%0d want 0 0", t1, t2); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_one_shot();
    test_repeat();
    test_priority();
    test_zero_saturation();
    test_simultaneous();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
